// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID pipeline register record used by the fetch stage.
package cpu_pkg;

  localparam int unsigned    XLEN     = 32;
  localparam logic [31:0]    NOP_INST = 32'h0000_0000;
  localparam logic [31:0]    PC_RESET = 32'h0000_0000;
  localparam logic [31:0]    PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc    = '0;
    b.inst  = NOP_INST;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection (start > branch > PC_write > PC+4).
module pc_reg
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            PC_write_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Plain 32-bit add: 0xFFFFFFFC wraps to 0 with no carry out.
  assign pc_plus4_o = r_pc + PC_STEP;
  assign pc_o       = r_pc;

  always_comb begin
    w_pc_next = r_pc;
    if (!start_i)
      w_pc_next = r_pc;
    else if (branch_taken_i)
      w_pc_next = branch_target_i;
    else if (PC_write_i)
      w_pc_next = pc_plus4_o;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_pc <= PC_RESET;
    else
      r_pc <= w_pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC (pc_reg), IF/ID pipeline register, optional perf counters.
// Define IF_PERF_CNT_EN to build the saturating stall/flush counters; otherwise they read 0.
module if_stage
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            PC_write_i,
  input  logic            IF_ID_write_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] IF_ID_pc_o,
  output logic [XLEN-1:0] IF_ID_inst_o,
  output logic            IF_ID_valid_o,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
);

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  if_id_t          r_if_id;
  if_id_t          w_if_id_next;

  pc_reg u_pc_reg (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .PC_write_i      (PC_write_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pc_o            (w_pc),
    .pc_plus4_o      (w_pc_plus4)
  );

  assign inst_addr_o = w_pc;

  // Flush outranks start_i and IF_ID_write_i, so a branch during a stall still bubbles.
  always_comb begin
    w_if_id_next = r_if_id;
    if (branch_taken_i || !start_i) begin
      w_if_id_next = if_id_bubble();
    end else if (IF_ID_write_i) begin
      w_if_id_next.pc    = w_pc_plus4;
      w_if_id_next.inst  = inst_i;
      w_if_id_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_if_id <= if_id_bubble();
    else
      r_if_id <= w_if_id_next;
  end

  assign IF_ID_pc_o    = r_if_id.pc;
  assign IF_ID_inst_o  = r_if_id.inst;
  assign IF_ID_valid_o = r_if_id.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_stall_evt;
  logic        w_flush_evt;

  assign w_stall_evt = start_i && !branch_taken_i && !PC_write_i;
  assign w_flush_evt = start_i && branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_evt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage; counter expectations follow IF_PERF_CNT_EN.
module tb_if_stage;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        PC_write_i;
  logic        IF_ID_write_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_o;
  logic [31:0] IF_ID_pc_o;
  logic [31:0] IF_ID_inst_o;
  logic        IF_ID_valid_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  int unsigned n_pass;
  int unsigned n_total;

  if_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .PC_write_i      (PC_write_i),
    .IF_ID_write_i   (IF_ID_write_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .inst_i          (inst_i),
    .inst_addr_o     (inst_addr_o),
    .IF_ID_pc_o      (IF_ID_pc_o),
    .IF_ID_inst_o    (IF_ID_inst_o),
    .IF_ID_valid_o   (IF_ID_valid_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hDEAD_0001;
  endfunction

  // Asynchronous instruction memory: address-derived pattern, never zero.
  assign inst_i = imem(inst_addr_o);

  typedef struct {
    logic        start;
    logic        pcw;
    logic        ifw;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [31:0] e_stall;
    logic [31:0] e_flush;
  } vec_t;

  localparam int unsigned NV = 16;
  vec_t vt [NV];

  function automatic vec_t mk(input logic s, input logic pw, input logic iw, input logic b,
                              input logic [31:0] t, input logic [31:0] ea, input logic [31:0] ep,
                              input logic [31:0] ei, input logic ev,
                              input logic [31:0] es, input logic [31:0] ef);
    vec_t v;
    v.start = s; v.pcw = pw; v.ifw = iw; v.br = b; v.tgt = t;
    v.e_addr = ea; v.e_pc = ep; v.e_inst = ei; v.e_valid = ev;
`ifdef IF_PERF_CNT_EN
    v.e_stall = es; v.e_flush = ef;
`else
    v.e_stall = '0; v.e_flush = '0;
    if (es != ef) v.e_stall = '0;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] ep,
                           input logic [31:0] ei, input logic ev,
                           input logic [31:0] es, input logic [31:0] ef);
    check({tag, ".inst_addr"}, inst_addr_o, ea);
    check({tag, ".IF_ID_pc"}, IF_ID_pc_o, ep);
    check({tag, ".IF_ID_inst"}, IF_ID_inst_o, ei);
    check({tag, ".IF_ID_valid"}, {31'd0, IF_ID_valid_o}, {31'd0, ev});
    check({tag, ".stall_cnt"}, stall_cnt_o, es);
    check({tag, ".flush_cnt"}, flush_cnt_o, ef);
  endtask

  logic [31:0] zc;

  initial begin
    n_pass = 0;
    n_total = 0;
    zc = '0;
    rst_i = 1'b0;
    start_i = 1'b0;
    PC_write_i = 1'b1;
    IF_ID_write_i = 1'b1;
    branch_taken_i = 1'b0;
    branch_target_i = '0;

    //            st pw iw br tgt            addr           IF_ID pc       IF_ID inst            v  stall flush
    vt[0]  = mk(1, 1, 1, 0, 32'h0,         32'h4,         32'h4,         imem(32'h0),          1, 0, 0);
    vt[1]  = mk(1, 1, 1, 0, 32'h0,         32'h8,         32'h8,         imem(32'h4),          1, 0, 0);
    vt[2]  = mk(1, 0, 0, 0, 32'h0,         32'h8,         32'h8,         imem(32'h4),          1, 1, 0);
    vt[3]  = mk(1, 1, 1, 0, 32'h0,         32'hC,         32'hC,         imem(32'h8),          1, 1, 0);
    vt[4]  = mk(1, 1, 1, 0, 32'h0,         32'h10,        32'h10,        imem(32'hC),          1, 1, 0);
    vt[5]  = mk(1, 1, 1, 1, 32'h40,        32'h40,        32'h0,         32'h0,                0, 1, 1);
    vt[6]  = mk(1, 1, 1, 0, 32'h0,         32'h44,        32'h44,        imem(32'h40),         1, 1, 1);
    vt[7]  = mk(1, 0, 0, 1, 32'h80,        32'h80,        32'h0,         32'h0,                0, 1, 2);
    vt[8]  = mk(0, 1, 1, 0, 32'h0,         32'h80,        32'h0,         32'h0,                0, 1, 2);
    vt[9]  = mk(0, 1, 1, 1, 32'h200,       32'h80,        32'h0,         32'h0,                0, 1, 2);
    vt[10] = mk(1, 1, 1, 0, 32'h0,         32'h84,        32'h84,        imem(32'h80),         1, 1, 2);
    vt[11] = mk(1, 0, 1, 0, 32'h0,         32'h84,        32'h88,        imem(32'h84),         1, 2, 2);
    vt[12] = mk(1, 1, 0, 0, 32'h0,         32'h88,        32'h88,        imem(32'h84),         1, 2, 2);
    vt[13] = mk(1, 1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,                0, 2, 3);
    vt[14] = mk(1, 1, 1, 0, 32'h0,         32'h0,         32'h0,         imem(32'hFFFF_FFFC),  1, 2, 3);
    vt[15] = mk(1, 1, 1, 0, 32'h0,         32'h4,         32'h4,         imem(32'h0),          1, 2, 3);

    // Reset held across edges with fetch enabled
    start_i = 1'b1;
    branch_taken_i = 1'b1;
    branch_target_i = 32'h1234_5678;
    repeat (2) @(posedge clk_i);
    #1 check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, zc, zc);

    @(negedge clk_i);
    start_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = '0;
    rst_i = 1'b1;
    #1 check("first_fetch_addr", inst_addr_o, 32'h0);

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk_i);
      start_i         = vt[i].start;
      PC_write_i      = vt[i].pcw;
      IF_ID_write_i   = vt[i].ifw;
      branch_taken_i  = vt[i].br;
      branch_target_i = vt[i].tgt;
      @(posedge clk_i);
      #1 check_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_pc, vt[i].e_inst,
                   vt[i].e_valid, vt[i].e_stall, vt[i].e_flush);
    end

    // Asynchronous reset mid-cycle while IF/ID holds a valid entry
    check("pre_reset_valid", {31'd0, IF_ID_valid_o}, 32'd1);
    #3 rst_i = 1'b0;
    #1 check_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, zc, zc);

    // Release with fetch disabled: nothing moves until start_i rises
    @(negedge clk_i);
    rst_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk_i);
    #1 check_all("post_reset_idle", 32'h0, 32'h0, 32'h0, 1'b0, zc, zc);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 check_all("post_reset_fetch", 32'h4, 32'h4, imem(32'h0), 1'b1, zc, zc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
